// File: rtl/log_capture_pkg.sv
// Shared definitions for the capture buffer and the file register that reads it.
package log_capture_pkg;

    // Capture FSM encoding; the unused code 2'd3 is treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_e;

    // Number of address bits needed to index `value` entries (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Kept free of resets and read-side muxing so synthesis maps it to block RAM.
module sdp_ram
    import log_capture_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = clogb2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port.
    // NOTE: the array has no reset; a reset loop over every word would stop
    // the tools from mapping it onto a block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its last word while rd_en is low.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/log_capture.sv
// Capture buffer between the I/Q transmit filters and the file register.
// A rising edge of i_run_log records RAM_DEPTH consecutive words of i_data,
// then flags full; outside of a capture the micro reads words back by address.
module log_capture
    import log_capture_pkg::*;
#(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int NB_ADDR   = 15
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_run_log,
    input  logic                 i_read_log,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [RAM_WIDTH-1:0] i_data,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_mem_full,
    output logic                 o_capturing
);

    localparam int AW = clogb2(RAM_DEPTH);
    // One extra bit so RAM_DEPTH itself is representable when NB_ADDR == AW.
    localparam logic [NB_ADDR:0] DEPTH_EXT = (NB_ADDR + 1)'(RAM_DEPTH);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(RAM_DEPTH - 1);

    state_e         state_q,    state_d;
    logic           run_dly_q,  run_dly_d;
    logic [AW-1:0]  wr_addr_q,  wr_addr_d;
    // Set when the last honoured read was out of range (or after reset), so
    // o_data shows zero instead of the RAM's held read word.
    logic           zero_out_q, zero_out_d;

    logic                 run_rise;
    logic                 rd_req;
    logic                 addr_in_range;
    logic                 ram_wr_en;
    logic                 ram_rd_en;
    logic [RAM_WIDTH-1:0] ram_rd_data;

    assign run_rise      = i_run_log & ~run_dly_q;
    assign addr_in_range = ({1'b0, i_addr} < DEPTH_EXT);

    // Next-state, write-counter and write-enable logic of the capture FSM.
    // NOTE: every signal gets its default before the case; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        ram_wr_en = 1'b0;
        run_dly_d = i_run_log;

        case (state_q)
            CAPTURE: begin
                // A run edge here is deliberately ignored: no restart mid-capture.
                ram_wr_en = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // A new run overwrites the previous capture.
                if (run_rise) begin
                    wr_addr_d = '0;
                    state_d   = CAPTURE;
                end
            end
            default: begin
                // IDLE, and the unused code which recovers as IDLE.
                state_d = IDLE;
                if (run_rise) begin
                    wr_addr_d = '0;
                    state_d   = CAPTURE;
                end
            end
        endcase
    end

    // Read-side control: reads are only honoured outside a capture.
    always_comb begin
        rd_req     = i_read_log & (state_q != CAPTURE);
        ram_rd_en  = rd_req & addr_in_range;
        zero_out_d = zero_out_q;
        if (rd_req) begin
            zero_out_d = ~addr_in_range;
        end
    end

    // State, edge-detect, write-address and output-select registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            run_dly_q  <= 1'b0;
            wr_addr_q  <= '0;
            zero_out_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            run_dly_q  <= run_dly_d;
            wr_addr_q  <= wr_addr_d;
            zero_out_q <= zero_out_d;
        end
    end

    sdp_ram #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (i_data),
        .rd_en   (ram_rd_en),
        .rd_addr (i_addr[AW-1:0]),
        .rd_data (ram_rd_data)
    );

    assign o_data      = zero_out_q ? '0 : ram_rd_data;
    assign o_capturing = (state_q == CAPTURE);
    assign o_mem_full  = (state_q == FULL);

endmodule

// File: tb/tb_log_capture.sv
// Randomized bench for log_capture: a reference memory image and an expected
// read-data queue are built from the stimulus; a monitor compares o_data.
module tb_log_capture;

    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int NA = 15;

    logic          clock      = 1'b0;
    logic          i_reset    = 1'b1;
    logic          i_run_log  = 1'b0;
    logic          i_read_log = 1'b0;
    logic [NA-1:0] i_addr     = '0;
    logic [W-1:0]  i_data     = '0;
    logic [W-1:0]  o_data;
    logic          o_mem_full;
    logic          o_capturing;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_mem [D];
    logic [W-1:0] exp_last   = '0;
    logic [W-1:0] exp_q [$];
    bit           chk_en     = 1'b0;
    bit           in_capture = 1'b0;

    log_capture #(
        .RAM_WIDTH (W),
        .RAM_DEPTH (D),
        .NB_ADDR   (NA)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_run_log   (i_run_log),
        .i_read_log  (i_read_log),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_mem_full  (o_mem_full),
        .o_capturing (o_capturing)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read presented before an edge yields o_data after that edge.
    initial begin
        forever begin
            bit sampled;
            @(posedge clock);
            sampled = chk_en;
            @(negedge clock);
            if (sampled) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_empty: got %0h, expected no read", o_data);
                end else begin
                    check("o_data", o_data, exp_q.pop_front());
                end
            end
        end
    end

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        i_read_log = 1'b0;
        chk_en     = 1'b0;
    endtask

    // Present a read for the next edge and queue the word it should return.
    task automatic issue_read(input logic [NA-1:0] addr);
        i_read_log = 1'b1;
        i_addr     = addr;
        chk_en     = 1'b1;
        if (!in_capture) begin
            exp_last = (int'(addr) < D) ? model_mem[int'(addr)] : '0;
        end
        exp_q.push_back(exp_last);
    endtask

    function automatic logic [NA-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return NA'($urandom_range(D, (1 << NA) - 1));
        return NA'($urandom_range(0, D - 1));
    endfunction

    // One run pulse followed by a capture; optional run glitch, read request
    // and reset at given capture cycles (-1 disables each).
    task automatic do_capture(input bit count_mode, input int glitch_at,
                              input int rd_at, input int reset_at);
        int           cap_cycles;
        logic [W-1:0] base;
        logic [W-1:0] v;
        cap_cycles = 0;
        base       = $urandom;
        i_run_log  = 1'b1;
        i_data     = $urandom;
        step();
        i_run_log  = 1'b0;
        in_capture = 1'b1;
        check("full_clear_at_start", {31'b0, o_mem_full}, 32'd0);
        check("capturing_at_start", {31'b0, o_capturing}, 32'd1);
        for (int k = 0; k < D; k++) begin
            if (k == reset_at) begin
                i_reset = 1'b0;
                #2;
                check("capturing_in_reset", {31'b0, o_capturing}, 32'd0);
                check("full_in_reset", {31'b0, o_mem_full}, 32'd0);
                check("o_data_in_reset", o_data, 32'd0);
                in_capture = 1'b0;
                exp_last   = '0;
                #2;
                i_reset = 1'b1;
                return;
            end
            if (o_capturing) cap_cycles++;
            v            = count_mode ? base + W'(k) : W'($urandom);
            i_data       = v;
            model_mem[k] = v;
            i_run_log    = (k == glitch_at);
            if (k == rd_at) issue_read(rand_addr());
            step();
        end
        i_run_log  = 1'b0;
        in_capture = 1'b0;
        check("capture_length", W'(cap_cycles), W'(D));
        check("full_after_capture", {31'b0, o_mem_full}, 32'd1);
        check("capturing_after", {31'b0, o_capturing}, 32'd0);
    endtask

    initial begin
        #1;
        i_reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        i_reset = 1'b1;
        repeat (2) step();
        check("reset_o_data", o_data, 32'd0);
        check("reset_full", {31'b0, o_mem_full}, 32'd0);
        check("reset_capturing", {31'b0, o_capturing}, 32'd0);

        // Counter data, single run pulse.
        do_capture(1'b1, -1, -1, -1);
        issue_read(NA'(0));     step();
        issue_read(NA'(1));     step();
        issue_read(NA'(1023));  step();
        issue_read(NA'(1024));  step();
        issue_read(15'h7FFF);   step();
        issue_read(NA'(5));     step();
        for (int i = 0; i < 20; i++) begin
            issue_read(rand_addr());
            step();
        end
        step();

        // Rise while FULL, run glitch mid-capture, read during capture.
        do_capture(1'b0, 300, 400, -1);
        issue_read(NA'(0));     step();
        issue_read(NA'(1023));  step();
        for (int i = 0; i < 10; i++) begin
            issue_read(rand_addr());
            step();
        end
        step();

        // Reset at capture cycle 500, then idle-state reads of the known image.
        do_capture(1'b0, -1, 100, 500);
        step();
        step();
        check("idle_full", {31'b0, o_mem_full}, 32'd0);
        check("idle_capturing", {31'b0, o_capturing}, 32'd0);
        issue_read(NA'(10));    step();
        issue_read(NA'(700));   step();
        step();

        // Fresh capture after reset.
        do_capture(1'b0, -1, -1, -1);
        issue_read(NA'(0));     step();
        for (int i = 0; i < 10; i++) begin
            issue_read(rand_addr());
            step();
        end
        repeat (2) step();

        check("scoreboard_drained", W'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/log_capture.md
# log_capture

Capture memory between the I/Q transmit filters and the file register. On a rising edge of the run command it records RAM_DEPTH consecutive words of the packed filter output, `{16'b0, filter_Q, filter_I}`, one word per clock, then flags full. Once capture is finished, the file register reads any word back by address for the micro. Writes and reads never overlap in time.

## Interface
- RAM_WIDTH, 32, width of one logged word.
- RAM_DEPTH, 1024, number of words per capture; must be a power of two, at least 2.
- NB_ADDR, 15, width of the read address from the file register.
- clock  input  1  system clock, 100 MHz.
- i_reset  input  1  one clock; reset is asynchronous and active-low.
- i_run_log  input  1  level from the file register; a rising edge starts a capture.
- i_read_log  input  1  read enable, level.
- i_addr  input  NB_ADDR  read address.
- i_data  input  RAM_WIDTH  word to log, sampled every clock while capturing.
- o_data  output  RAM_WIDTH  read data, registered.
- o_mem_full  output  1  capture complete; the buffer holds RAM_DEPTH valid words.
- o_capturing  output  1  a capture is in progress.

## Operation
- Internal signals:
  - run_d: i_run_log delayed one clock; run_rise = i_run_log & ~run_d.
  - wr_addr: clogb2(RAM_DEPTH) bits.
- FSM states: IDLE, CAPTURE, FULL.
- IDLE:
  - run_rise: wr_addr <= 0, go to CAPTURE.
- CAPTURE:
  - Write mem[wr_addr] <= i_data every clock, then wr_addr++.
  - When writing address RAM_DEPTH-1, go to FULL.
  - run_rise is ignored; there is no restart mid-capture.
- FULL:
  - o_mem_full = 1.
  - run_rise: clear full, wr_addr <= 0, go to CAPTURE. This overwrites the previous capture.
- Reads:
  - Honoured in IDLE and FULL when i_read_log = 1.
  - If i_addr < RAM_DEPTH: o_data <= mem[i_addr].
  - If i_addr >= RAM_DEPTH (out of range): o_data <= 0.
  - While i_read_log = 0, o_data holds its value.
  - In CAPTURE, read requests are ignored and o_data holds.
- Outputs:
  - o_capturing = (state == CAPTURE).
  - o_mem_full = (state == FULL).
  - Both are decoded from the state register; they are not combinational from the inputs.
- Reset:
  - Any state goes to IDLE; wr_addr = 0, run_d = 0, o_data = 0.
  - o_mem_full = 0 and o_capturing = 0.
  - Memory contents are not cleared.
  - Reset mid-capture discards the capture; a new run_rise is required.
- i_run_log held high across reset release: run_d resets to 0, so the first clock after release sees run_rise. This is intended: a capture starts.

## Timing
- run_rise is detected at edge N (i_run_log is 1 at edge N, run_d is 0). The state is CAPTURE after edge N.
- The first word written is i_data sampled at edge N+1 (mem[0]). mem[k] = i_data at edge N+1+k.
- The last write is at edge N+RAM_DEPTH; o_mem_full = 1 after that edge.
- Capture lasts exactly RAM_DEPTH cycles.
- Read latency is 1 clock: address and read enable are applied before edge M; o_data is valid after edge M.
- Back-to-back reads on consecutive cycles are supported, one word per clock.

## Structure
- Package log_capture_pkg holds:
  - state encoding: IDLE = 2'd0, CAPTURE = 2'd1, FULL = 2'd2; 2'd3 decodes to IDLE;
  - the clogb2 function, shared with the file register.
- Sub-module sdp_ram: simple dual-port RAM with one write port and one registered read port, written so synthesis infers block RAM.
  - No reset on the array.
  - The o_data reset and out-of-range zeroing are done in log_capture around sdp_ram.
- log_capture contains the FSM, edge detect, write counter and read-range check.

## Test plan
- Reset release, no stimulus:
  - o_data = 0, o_mem_full = 0, o_capturing = 0.
  - Reads in IDLE before any capture are not checked; the uninitialised memory makes them undefined.
- i_data = counter value incrementing each clock, single run pulse: o_capturing stays high for exactly 1024 cycles, then o_mem_full = 1. Reading addresses 0, 1, 1023 returns c0, c0+1, c0+1023, where c0 = i_data at edge N+1.
- Read with i_addr = 1024 and i_addr = 0x7FFF after full: o_data = 0 one clock later. Address 5 on the next cycle returns mem[5].
- Second run_rise mid-capture (at cycle 300): ignored; o_mem_full still rises at cycle 1024. Reads during capture leave o_data unchanged.
- i_reset pulsed low at capture cycle 500: o_capturing drops immediately and o_mem_full = 0. After release, a new run_rise starts a fresh capture that fills 1024 words.
- Run rise while FULL: o_mem_full clears the next clock. The new data overwrites: after completion, mem[0] holds the new capture's first word.
